i2s_dac_tx: RTL and testbench

Audio-path consumer of the 12 MHz codec master clock produced by the audio PLL. Runs entirely in that clock domain and acts as I2S bus master toward the codec DAC. Derives BCLK and LRCK by counting, and serialises stereo PCM samples onto DACDAT. Samples arrive from upstream DSP logic over a valid/ready handshake and pass through a one-entry holding register.

---
 rtl/audio_pkg.sv | 12 +
 rtl/i2s_dac_tx_if.sv | 12 +
 rtl/i2s_timing_gen.sv | 59 +++++
 rtl/i2s_dac_tx.sv | 105 ++++++++++
 tb/tb_i2s_dac_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants and the stereo sample type exchanged between
// the upstream DSP and the I2S transmitter.
package audio_pkg;
    localparam int AUDIO_DATA_W = 16;
    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_HALF_DIV = 2;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } stereo_t;
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Valid/ready sample-pair stream from the DSP into the I2S transmitter.
interface i2s_dac_tx_if #(
    parameter int DATA_W = audio_pkg::AUDIO_DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_timing_gen.sv
// BCLK/LRCK generator: div_cnt splits clk into BCLK halves, bit_cnt counts
// BCLK periods across the two channel slots of a frame.
module i2s_timing_gen import audio_pkg::*; #(
    parameter  int SLOT_W   = I2S_SLOT_W,
    parameter  int HALF_DIV = I2S_HALF_DIV,
    localparam int P_W      = $clog2(SLOT_W)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bclk,
    output logic           lrck,
    output logic           bit_fall,
    output logic           frame_boundary,
    output logic [P_W-1:0] p
);
    localparam int DIV_W = $clog2(2*HALF_DIV);
    localparam int BIT_W = $clog2(2*SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*HALF_DIV-1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrck_q, lrck_d;

    // Strobes are high in the cycle whose closing edge is the BCLK falling
    // edge; p is the slot position of the bit launched on that edge.
    always_comb begin
        bit_fall       = (div_cnt_q == DIV_LAST);
        frame_boundary = bit_fall && (bit_cnt_q == BIT_LAST);
        div_cnt_d      = bit_fall ? '0 : div_cnt_q + DIV_W'(1);
        bit_cnt_d      = bit_cnt_q;
        if (bit_fall) begin
            bit_cnt_d = frame_boundary ? '0 : bit_cnt_q + BIT_W'(1);
        end
        bclk_d = (div_cnt_d >= DIV_HALF);
        lrck_d = (bit_cnt_d >= BIT_SLOT);
        p      = lrck_d ? P_W'(bit_cnt_d - BIT_SLOT) : P_W'(bit_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrck_q    <= lrck_d;
        end
    end

    assign bclk = bclk_q;
    assign lrck = lrck_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter toward the codec DAC: one-entry holding register in
// front of a frame-wide shift register serialised MSB first onto dacdat.
module i2s_dac_tx import audio_pkg::*; #(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int HALF_DIV = I2S_HALF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    i2s_dac_tx_if.slave  s_if,
    output logic         bclk,
    output logic         lrck,
    output logic         dacdat,
    output logic         frame_start,
    output logic         underflow
);
    localparam int P_W = $clog2(SLOT_W);
    localparam logic [P_W-1:0] P_LAST_BIT = P_W'(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    pair_t               hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [2*DATA_W-1:0] shift_q, shift_d;
    logic                dacdat_q, dacdat_d;
    logic                frame_start_q, frame_start_d;
    logic                underflow_q, underflow_d;

    logic           bit_fall;
    logic           frame_boundary;
    logic [P_W-1:0] p;
    logic           accept;

    i2s_timing_gen #(
        .SLOT_W   (SLOT_W),
        .HALF_DIV (HALF_DIV)
    ) u_timing (
        .clk            (clk),
        .rst            (rst),
        .bclk           (bclk),
        .lrck           (lrck),
        .bit_fall       (bit_fall),
        .frame_boundary (frame_boundary),
        .p              (p)
    );

    // A boundary frees the holding register in the same cycle, so a new pair
    // may be taken while the old one moves into the shifter.
    assign s_if.s_ready = !rst && (!hold_full_q || frame_boundary);
    assign accept       = s_if.s_valid && s_if.s_ready;

    always_comb begin
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        dacdat_d      = dacdat_q;
        frame_start_d = frame_boundary;
        underflow_d   = frame_boundary && !hold_full_q;

        // Left bits leave first, so the right word is at the top by the time
        // the right slot starts.
        if (bit_fall) begin
            dacdat_d = 1'b0;
            if (p != '0 && p <= P_LAST_BIT) begin
                dacdat_d = shift_q[2*DATA_W-1];
                shift_d  = {shift_q[2*DATA_W-2:0], 1'b0};
            end
        end

        if (frame_boundary) begin
            shift_d     = hold_full_q ? {hold_q.left, hold_q.right} : '0;
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_d      = '{left: s_if.s_left, right: s_if.s_right};
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign dacdat      = dacdat_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: frame-level reference model checked every cycle,
// slot-word vector table, and directed streaming/underflow/reset sequences.
module tb_i2s_dac_tx;
    import audio_pkg::*;

    localparam int DW    = AUDIO_DATA_W;
    localparam int SW    = I2S_SLOT_W;
    localparam int HD    = I2S_HALF_DIV;
    localparam int BITP  = 2*HD;
    localparam int FRAME = 4*SW*HD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk, lrck, dacdat, frame_start, underflow;

    i2s_dac_tx_if #(.DATA_W(DW)) s_if ();

    i2s_dac_tx #(.DATA_W(DW), .SLOT_W(SW), .HALF_DIV(HD)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (s_if),
        .bclk        (bclk),
        .lrck        (lrck),
        .dacdat      (dacdat),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        logic [SW-1:0] lslot;
        logic [SW-1:0] rslot;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: n = clk cycles since reset release, q = pairs waiting for a
    // frame (capacity one), cur = pair owning the current frame.
    int      n = 0;
    stereo_t q[$];
    stereo_t cur = '0;
    bit      m_fs = 1'b0, m_uf = 1'b0;
    bit      last_acc = 1'b0;
    bit      dut_acc = 1'b0;
    int      dut_acc_n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, got, exp, n);
        end
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        s_if.s_valid = v;
        s_if.s_left  = l;
        s_if.s_right = r;
    endtask

    task automatic check_outputs();
        int            bi, p, ch;
        logic [DW-1:0] w;
        logic          ed;
        bi = (n / BITP) % (2*SW);
        p  = bi % SW;
        ch = bi / SW;
        w  = (ch != 0) ? cur.right : cur.left;
        ed = (p >= 1 && p <= DW) ? w[DW-p] : 1'b0;
        chk("bclk", bclk, ((n % BITP) >= HD));
        chk("lrck", lrck, 32'(ch));
        chk("dacdat", dacdat, ed);
        chk("frame_start", frame_start, m_fs);
        chk("underflow", underflow, m_uf);
    endtask

    task automatic step();
        logic    rdy;
        stereo_t inp;
        #1;
        rdy = !rst && (q.size() == 0 || ((n + 1) % FRAME) == 0);
        chk("s_ready", s_if.s_ready, rdy);
        inp.left  = s_if.s_left;
        inp.right = s_if.s_right;
        last_acc  = s_if.s_valid && rdy;
        dut_acc   = (s_if.s_valid === 1'b1) && (s_if.s_ready === 1'b1);
        if (dut_acc) dut_acc_n = n;
        @(posedge clk);
        if (rst) begin
            n = 0;
            q.delete();
            cur  = '0;
            m_fs = 1'b0;
            m_uf = 1'b0;
        end else begin
            n++;
            m_fs = 1'b0;
            m_uf = 1'b0;
            if (n % FRAME == 0) begin
                m_fs = 1'b1;
                if (q.size() != 0) cur = q.pop_front();
                else begin
                    cur  = '0;
                    m_uf = 1'b1;
                end
            end
            if (last_acc) q.push_back(inp);
        end
        #1;
        check_outputs();
    endtask

    task automatic wait_accept();
        int k = 0;
        do begin step(); k++; end while (!dut_acc && k < 2*FRAME);
        chk("accept_timeout", dut_acc, 1);
    endtask

    // Advances to the next frame_start seen on the DUT (always at least one cycle).
    task automatic run_to_boundary();
        int k = 0;
        do begin step(); k++; end while (frame_start !== 1'b1 && k < 2*FRAME);
        chk("frame_start_timeout", frame_start, 1);
    endtask

    task automatic capture(output logic [SW-1:0] ls, output logic [SW-1:0] rs);
        ls = '0;
        rs = '0;
        for (int i = 0; i < FRAME; i++) begin
            if (n % BITP == 0) begin
                if ((n % FRAME) >= FRAME/2) rs = {rs[SW-2:0], dacdat};
                else                        ls = {ls[SW-2:0], dacdat};
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        logic [SW-1:0] ls, rs;
        logic [DW-1:0] word;
        int            cnt, accs, ufs, ones;

        vecs[0] = '{16'hA5C3, 16'h8001, 32'h52E18000, 32'h40008000};
        vecs[1] = '{16'hFFFF, 16'h0001, 32'h7FFF8000, 32'h00008000};
        vecs[2] = '{16'h8000, 16'h1234, 32'h40000000, 32'h091A0000};
        vecs[3] = '{16'h0000, 16'h7FFF, 32'h00000000, 32'h3FFF8000};
        vecs[4] = '{16'h5555, 16'hAAAA, 32'h2AAA8000, 32'h55550000};
        vecs[5] = '{16'h0001, 16'h8000, 32'h00008000, 32'h40000000};

        set_in(1'b0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step();
        step();
        chk("reset_s_ready", s_if.s_ready, 0);
        chk("reset_dacdat", dacdat, 0);

        // Silent first frame; first frame_start/underflow at cycle FRAME.
        rst = 1'b0;
        ones = 0;
        cnt  = 0;
        do begin
            ones += int'(dacdat === 1'b1);
            step();
            cnt++;
        end while (frame_start !== 1'b1 && cnt < 2*FRAME);
        chk("first_frame_start_cycle", n, FRAME);
        chk("first_underflow", underflow, 1);
        chk("first_frame_silent", ones, 0);

        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].left, vecs[i].right);
            wait_accept();
            set_in(1'b0, '0, '0);
            run_to_boundary();
            capture(ls, rs);
            chk("vec_lslot", ls, vecs[i].lslot);
            chk("vec_rslot", rs, vecs[i].rslot);
        end

        // Continuous streaming: entry cycle plus four boundary cycles accept.
        word = 16'h0100;
        accs = 0;
        ufs  = 0;
        for (int i = 0; i < 4*FRAME; i++) begin
            set_in(1'b1, word, ~word);
            step();
            if (dut_acc) begin
                accs++;
                if (accs > 1) chk("stream_accept_phase", dut_acc_n % FRAME, FRAME-1);
                word = word + 1'b1;
            end
            ufs += int'(underflow === 1'b1);
        end
        chk("stream_transfers", accs, 5);
        chk("stream_underflows", ufs, 0);

        // Stop: current and held pair drain, then three empty frames.
        set_in(1'b0, '0, '0);
        ufs = 0;
        for (int i = 0; i < 4*FRAME; i++) begin
            step();
            ufs += int'(underflow === 1'b1);
        end
        chk("drain_underflows", ufs, 3);
        set_in(1'b1, 16'hFFFF, 16'hFFFF);
        wait_accept();
        set_in(1'b0, '0, '0);
        run_to_boundary();
        chk("resume_no_underflow", underflow, 0);

        // Reset in the right slot while a pair is held.
        set_in(1'b1, 16'hFFFF, 16'hFFFF);
        wait_accept();
        set_in(1'b0, '0, '0);
        cnt = 0;
        while ((n % FRAME) != 150 && cnt < 2*FRAME) begin step(); cnt++; end
        chk("pre_rst_dacdat", dacdat, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_bclk", bclk, 0);
        chk("rst_mid_lrck", lrck, 0);
        chk("rst_mid_dacdat", dacdat, 0);
        chk("rst_mid_s_ready", s_if.s_ready, 0);
        rst  = 1'b0;
        ones = 0;
        ufs  = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            step();
            ones += int'(dacdat === 1'b1);
            ufs  += int'(underflow === 1'b1);
        end
        chk("post_rst_silent", ones, 0);
        chk("post_rst_underflows", ufs, 2);

        // Random sparse traffic against the model.
        for (int i = 0; i < 20*FRAME; i++) begin
            set_in(($urandom_range(0, 299) == 0), DW'($urandom), DW'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
